// File: rtl/edge_counter_sequencer.sv
// Purpose : sequences clear/arm/trigger-wait/count-window/drain for a bank of edge counters.
// Latency : every output is registered, so it changes on the edge where the state changes.
// Backpres: none; a start is accepted only in IDLE, otherwise it is dropped.
module edge_counter_sequencer #(
   parameter int NUM_CH       = 4,
   parameter int WIN_W        = 32,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic              clk,
   input  logic              rst_n_sync,
   input  logic              start,
   input  logic              abort,
   input  logic [NUM_CH-1:0] cfg_chan_en,
   input  logic              cfg_wait_trig,
   input  logic [WIN_W-1:0]  cfg_trig_timeout,
   input  logic [WIN_W-1:0]  cfg_window,
   input  logic [NUM_CH-1:0] trig_in,
   output logic [NUM_CH-1:0] enable,
   output logic [NUM_CH-1:0] trig_enable,
   output logic [NUM_CH-1:0] counter_clr,
   output logic              busy,
   output logic              done,
   output logic [1:0]        status,
   output logic [WIN_W-1:0]  window_remaining
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_WAIT_TRIG,
      S_MEASURE,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam int               DRN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DRN_W-1:0] DRN_ONE  = DRN_W'(1);
   localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);
   localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
   localparam logic [WIN_W-1:0] WIN_MAX  = '1;

   localparam logic [1:0] ST_NONE    = 2'b00;
   localparam logic [1:0] ST_OK      = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;
   localparam logic [1:0] ST_ABORT   = 2'b11;

   state_t             state_q, state_d;

   // shadow copy of the configuration, frozen at the accepted start
   logic [NUM_CH-1:0]  mask_q, mask_d;
   logic               wait_trig_q, wait_trig_d;
   logic [WIN_W-1:0]   timeout_q, timeout_d;
   logic [WIN_W-1:0]   window_q, window_d;

   logic [WIN_W-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic [DRN_W-1:0]   drain_cnt_q, drain_cnt_d;
   logic [WIN_W-1:0]   win_rem_q, win_rem_d;

   logic [NUM_CH-1:0]  enable_q, enable_d;
   logic [NUM_CH-1:0]  trig_enable_q, trig_enable_d;
   logic [NUM_CH-1:0]  counter_clr_q, counter_clr_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [1:0]         status_q, status_d;

   logic               trig_hit;
   logic [WIN_W-1:0]   win_load;

   assign trig_hit = |(trig_in & mask_q);
   // a programmed window of 0 still gives one counting cycle
   assign win_load = (window_q == '0) ? WIN_ONE : window_q;

   // next-state, shadow config, counters and completion status
   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      wait_trig_d = wait_trig_q;
      timeout_d   = timeout_q;
      window_d    = window_q;
      tmo_cnt_d   = tmo_cnt_q;
      drain_cnt_d = drain_cnt_q;
      win_rem_d   = '0;
      status_d    = status_q;

      case (state_q)
         S_IDLE: begin
            if (start && (cfg_chan_en != '0)) begin
               state_d     = S_ARM;
               mask_d      = cfg_chan_en;
               wait_trig_d = cfg_wait_trig;
               timeout_d   = cfg_trig_timeout;
               window_d    = cfg_window;
               status_d    = ST_NONE;
            end
         end
         S_ARM: begin
            if (abort) begin
               state_d  = S_DONE;
               status_d = ST_ABORT;
            end else if (wait_trig_q) begin
               state_d   = S_WAIT_TRIG;
               tmo_cnt_d = '0;
            end else begin
               state_d   = S_MEASURE;
               win_rem_d = win_load;
            end
         end
         S_WAIT_TRIG: begin
            // abort beats trigger, trigger beats timeout
            if (abort) begin
               state_d  = S_DONE;
               status_d = ST_ABORT;
            end else if (trig_hit) begin
               state_d   = S_MEASURE;
               win_rem_d = win_load;
            end else if ((timeout_q != '0) && (tmo_cnt_q == (timeout_q - WIN_ONE))) begin
               state_d  = S_DONE;
               status_d = ST_TIMEOUT;
            end else if (tmo_cnt_q != WIN_MAX) begin
               tmo_cnt_d = tmo_cnt_q + WIN_ONE;
            end
         end
         S_MEASURE: begin
            if (abort) begin
               state_d  = S_DONE;
               status_d = ST_ABORT;
            end else if (win_rem_q == WIN_ONE) begin
               state_d     = S_DRAIN;
               drain_cnt_d = '0;
            end else begin
               win_rem_d = win_rem_q - WIN_ONE;
            end
         end
         S_DRAIN: begin
            if (abort) begin
               state_d  = S_DONE;
               status_d = ST_ABORT;
            end else if (drain_cnt_q == DRN_LAST) begin
               state_d  = S_DONE;
               status_d = ST_OK;
            end else begin
               drain_cnt_d = drain_cnt_q + DRN_ONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // output decode from the upcoming state so every output is a flop
   always_comb begin
      enable_d      = '0;
      trig_enable_d = '0;
      counter_clr_d = '0;
      busy_d        = (state_d != S_IDLE);
      done_d        = (state_d == S_DONE);
      case (state_d)
         S_ARM:       counter_clr_d = mask_d;
         S_WAIT_TRIG: trig_enable_d = mask_d;
         S_MEASURE:   enable_d      = mask_d;
         default:     ;
      endcase
   end

   // state, config shadow, counters and output registers
   always_ff @(posedge clk) begin
      if (!rst_n_sync) begin
         state_q       <= S_IDLE;
         mask_q        <= '0;
         wait_trig_q   <= 1'b0;
         timeout_q     <= '0;
         window_q      <= '0;
         tmo_cnt_q     <= '0;
         drain_cnt_q   <= '0;
         win_rem_q     <= '0;
         enable_q      <= '0;
         trig_enable_q <= '0;
         counter_clr_q <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         status_q      <= ST_NONE;
      end else begin
         state_q       <= state_d;
         mask_q        <= mask_d;
         wait_trig_q   <= wait_trig_d;
         timeout_q     <= timeout_d;
         window_q      <= window_d;
         tmo_cnt_q     <= tmo_cnt_d;
         drain_cnt_q   <= drain_cnt_d;
         win_rem_q     <= win_rem_d;
         enable_q      <= enable_d;
         trig_enable_q <= trig_enable_d;
         counter_clr_q <= counter_clr_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         status_q      <= status_d;
      end
   end

   assign enable           = enable_q;
   assign trig_enable      = trig_enable_q;
   assign counter_clr      = counter_clr_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign status           = status_q;
   assign window_remaining = win_rem_q;

endmodule

// File: tb/tb_edge_counter_sequencer.sv
// Purpose : directed bench for edge_counter_sequencer with hand-computed expectations.
// Latency : inputs driven 1ns after the rising edge, outputs sampled at the same point.
// Backpres: n/a.
module tb_edge_counter_sequencer;

   logic        clk = 1'b0;
   logic        rst_n_sync;
   logic        start;
   logic        abort;
   logic [3:0]  cfg_chan_en;
   logic        cfg_wait_trig;
   logic [31:0] cfg_trig_timeout;
   logic [31:0] cfg_window;
   logic [3:0]  trig_in;
   logic [3:0]  enable;
   logic [3:0]  trig_enable;
   logic [3:0]  counter_clr;
   logic        busy;
   logic        done;
   logic [1:0]  status;
   logic [31:0] window_remaining;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   edge_counter_sequencer #(
      .NUM_CH       (4),
      .WIN_W        (32),
      .DRAIN_CYCLES (3)
   ) dut (
      .clk              (clk),
      .rst_n_sync       (rst_n_sync),
      .start            (start),
      .abort            (abort),
      .cfg_chan_en      (cfg_chan_en),
      .cfg_wait_trig    (cfg_wait_trig),
      .cfg_trig_timeout (cfg_trig_timeout),
      .cfg_window       (cfg_window),
      .trig_in          (trig_in),
      .enable           (enable),
      .trig_enable      (trig_enable),
      .counter_clr      (counter_clr),
      .busy             (busy),
      .done             (done),
      .status           (status),
      .window_remaining (window_remaining)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // advance n rising edges and settle 1ns past the last one
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // load config and pulse start for one edge; returns in the ARM cycle
   task automatic start_meas(input logic [3:0] m, input logic wt, input logic [31:0] tmo,
                             input logic [31:0] win);
      cfg_chan_en      = m;
      cfg_wait_trig    = wt;
      cfg_trig_timeout = tmo;
      cfg_window       = win;
      start            = 1'b1;
      step(1);
      start            = 1'b0;
   endtask

   // step until done is seen (bounded), counting enable / trig_enable cycles on the way
   task automatic wait_done(input int max, output int n_cyc, output int n_en,
                            output int n_trg, output logic seen);
      n_cyc = 0;
      n_en  = 0;
      n_trg = 0;
      while (!done && (n_cyc < max)) begin
         if (enable != 4'h0)      n_en++;
         if (trig_enable != 4'h0) n_trg++;
         step(1);
         n_cyc++;
      end
      seen = done;
   endtask

   int   n_cyc, n_en, n_trg, dcnt;
   logic seen;

   initial begin
      rst_n_sync       = 1'b0;
      start            = 1'b0;
      abort            = 1'b0;
      cfg_chan_en      = 4'h0;
      cfg_wait_trig    = 1'b0;
      cfg_trig_timeout = '0;
      cfg_window       = '0;
      trig_in          = 4'h0;
      step(3);

      // reset state
      chk("rst_busy",   {31'd0, busy}, 32'd0);
      chk("rst_done",   {31'd0, done}, 32'd0);
      chk("rst_status", {30'd0, status}, 32'd0);
      chk("rst_outs",   {20'd0, enable, trig_enable, counter_clr}, 32'd0);
      chk("rst_winrem", window_remaining, 32'd0);
      rst_n_sync = 1'b1;
      step(1);

      // no trigger, window 5; cfg changed mid-run must not matter
      start_meas(4'b0101, 1'b0, 32'd0, 32'd5);
      chk("nt_clr",     {28'd0, counter_clr}, 32'h5);
      chk("nt_busy",    {31'd0, busy}, 32'd1);
      chk("nt_en_arm",  {28'd0, enable}, 32'd0);
      step(1);
      chk("nt_en_first", {28'd0, enable}, 32'h5);
      chk("nt_wr_first", window_remaining, 32'd5);
      chk("nt_clr_off",  {28'd0, counter_clr}, 32'd0);
      cfg_chan_en = 4'hF;
      cfg_window  = 32'd100;
      step(4);
      chk("nt_en_last", {28'd0, enable}, 32'h5);
      chk("nt_wr_last", window_remaining, 32'd1);
      step(1);
      chk("nt_en_drain", {28'd0, enable}, 32'd0);
      chk("nt_wr_drain", window_remaining, 32'd0);
      chk("nt_busy_drain", {31'd0, busy}, 32'd1);
      step(2);
      chk("nt_done_early", {31'd0, done}, 32'd0);
      step(1);
      chk("nt_done",   {31'd0, done}, 32'd1);
      chk("nt_status", {30'd0, status}, 32'd1);
      step(1);
      chk("nt_done_pulse", {31'd0, done}, 32'd0);
      chk("nt_busy_end",   {31'd0, busy}, 32'd0);
      chk("nt_status_hold", {30'd0, status}, 32'd1);

      // triggered: wait forever, trigger on channel 1 twenty cycles after ARM
      start_meas(4'b0010, 1'b1, 32'd0, 32'd3);
      chk("tr_clr", {28'd0, counter_clr}, 32'h2);
      step(1);
      chk("tr_armed", {28'd0, trig_enable}, 32'h2);
      trig_in = 4'b1101;
      step(5);
      trig_in = 4'h0;
      chk("tr_unsel_ign", {28'd0, trig_enable}, 32'h2);
      chk("tr_unsel_en",  {28'd0, enable}, 32'd0);
      step(13);
      chk("tr_still_wait", {28'd0, trig_enable}, 32'h2);
      trig_in = 4'b0010;
      step(1);
      trig_in = 4'h0;
      chk("tr_en",    {28'd0, enable}, 32'h2);
      chk("tr_tе_off", {28'd0, trig_enable}, 32'd0);
      chk("tr_wr",    window_remaining, 32'd3);
      wait_done(50, n_cyc, n_en, n_trg, seen);
      chk("tr_seen",   {31'd0, seen}, 32'd1);
      chk("tr_en_cyc", n_en, 32'd3);
      chk("tr_cyc",    n_cyc, 32'd6);
      chk("tr_status", {30'd0, status}, 32'd1);
      step(1);

      // timeout 10 with a trigger held on an unselected channel
      trig_in = 4'b1000;
      start_meas(4'b0001, 1'b1, 32'd10, 32'd4);
      step(1);
      wait_done(50, n_cyc, n_en, n_trg, seen);
      trig_in = 4'h0;
      chk("to_seen",   {31'd0, seen}, 32'd1);
      chk("to_cyc",    n_cyc, 32'd10);
      chk("to_trg",    n_trg, 32'd10);
      chk("to_en",     n_en, 32'd0);
      chk("to_status", {30'd0, status}, 32'd2);
      step(1);

      // abort in MEASURE cycle 2, start held through DONE is ignored
      start_meas(4'hF, 1'b0, 32'd0, 32'd100);
      step(2);
      chk("ab_en",  {28'd0, enable}, 32'hF);
      chk("ab_wr",  window_remaining, 32'd99);
      abort = 1'b1;
      start = 1'b1;
      step(1);
      chk("ab_done",   {31'd0, done}, 32'd1);
      chk("ab_status", {30'd0, status}, 32'd3);
      chk("ab_en_off", {28'd0, enable}, 32'd0);
      chk("ab_busy",   {31'd0, busy}, 32'd1);
      abort = 1'b0;
      step(1);
      chk("ab_start_ign", {31'd0, busy}, 32'd0);
      chk("ab_stat_hold", {30'd0, status}, 32'd3);
      step(1);
      start = 1'b0;
      chk("ab_restart",  {31'd0, busy}, 32'd1);
      chk("ab_stat_clr", {30'd0, status}, 32'd0);
      chk("ab_clr",      {28'd0, counter_clr}, 32'hF);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      chk("ab_arm_done",   {31'd0, done}, 32'd1);
      chk("ab_arm_status", {30'd0, status}, 32'd3);
      step(1);

      // window 0 counts for a single cycle
      start_meas(4'b0100, 1'b0, 32'd0, 32'd0);
      step(1);
      chk("w0_wr", window_remaining, 32'd1);
      chk("w0_en", {28'd0, enable}, 32'h4);
      wait_done(20, n_cyc, n_en, n_trg, seen);
      chk("w0_seen",   {31'd0, seen}, 32'd1);
      chk("w0_en_cyc", n_en, 32'd1);
      chk("w0_cyc",    n_cyc, 32'd4);
      chk("w0_status", {30'd0, status}, 32'd1);
      step(1);

      // start with empty mask (and abort) in IDLE does nothing
      abort = 1'b1;
      start_meas(4'h0, 1'b0, 32'd0, 32'd5);
      abort = 1'b0;
      chk("m0_busy",   {31'd0, busy}, 32'd0);
      chk("m0_clr",    {28'd0, counter_clr}, 32'd0);
      chk("m0_done",   {31'd0, done}, 32'd0);
      chk("m0_status", {30'd0, status}, 32'd1);

      // trigger on the same cycle the timeout would fire
      start_meas(4'b0001, 1'b1, 32'd5, 32'd2);
      step(1);
      step(4);
      chk("tt_wait",  {28'd0, trig_enable}, 32'h1);
      chk("tt_ndone", {31'd0, done}, 32'd0);
      trig_in = 4'b0001;
      step(1);
      trig_in = 4'h0;
      chk("tt_en",    {28'd0, enable}, 32'h1);
      chk("tt_ndone2", {31'd0, done}, 32'd0);
      wait_done(20, n_cyc, n_en, n_trg, seen);
      chk("tt_seen",   {31'd0, seen}, 32'd1);
      chk("tt_en_cyc", n_en, 32'd2);
      chk("tt_status", {30'd0, status}, 32'd1);
      step(1);

      // reset during DRAIN: straight to IDLE, no done
      start_meas(4'b0011, 1'b0, 32'd0, 32'd1);
      step(1);
      chk("rd_en", {28'd0, enable}, 32'h3);
      step(1);
      chk("rd_drain", {31'd0, busy}, 32'd1);
      rst_n_sync = 1'b0;
      step(1);
      rst_n_sync = 1'b1;
      chk("rd_busy",   {31'd0, busy}, 32'd0);
      chk("rd_done",   {31'd0, done}, 32'd0);
      chk("rd_status", {30'd0, status}, 32'd0);
      chk("rd_outs",   {20'd0, enable, trig_enable, counter_clr}, 32'd0);
      dcnt = 0;
      for (int i = 0; i < 6; i++) begin
         step(1);
         if (done) dcnt++;
      end
      chk("rd_no_done", dcnt, 32'd0);
      chk("rd_idle",    {31'd0, busy}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/edge_counter_sequencer.md
Name: edge_counter_sequencer

Overview:
- Measurement sequencer for a bank of NUM_CH edge counters. It clears the counters and arms their trigger inputs, then optionally waits for a trigger from any selected channel.
- It then enables counting for a programmed window of clock cycles and lets the counter output pipeline settle before reporting completion.
- It sits between the SCARF register map, which supplies the cfg/start/abort inputs, and the edge counter instances, which receive enable/trig_enable/counter_clr.

Parameters:
- NUM_CH, 4, number of edge counter channels sequenced.
- WIN_W, 32, width of the window and timeout counters.
- DRAIN_CYCLES, 3, idle cycles after the window so the d1/d2/d3 count pipeline settles before done.

Ports:
- clk  input  1  single clock.
- rst_n_sync  input  1  reset, synchronous, active-low.
- start  input  1  one-cycle request to begin a measurement.
- abort  input  1  terminate the current measurement.
- cfg_chan_en  input  NUM_CH  channel select mask.
- cfg_wait_trig  input  1  1 = wait for a trigger before counting.
- cfg_trig_timeout  input  WIN_W  maximum cycles spent in WAIT_TRIG; 0 = wait forever.
- cfg_window  input  WIN_W  counting window length in cycles; 0 is treated as 1.
- trig_in  input  NUM_CH  trig_out from each edge counter.
- enable  output  NUM_CH  per-channel count enable.
- trig_enable  output  NUM_CH  per-channel trigger arm.
- counter_clr  output  NUM_CH  per-channel count clear pulse.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle completion pulse.
- status  output  2  00 none, 01 ok, 10 trigger timeout, 11 aborted.
- window_remaining  output  WIN_W  remaining window cycles while in MEASURE, otherwise 0.

Behaviour:
- Reset (rst_n_sync low at a clk edge): state=IDLE; all outputs 0; status=00; shadow config cleared. Reset mid-operation behaves the same, with no done pulse.
- Config is latched into shadow registers when start is accepted. cfg changes during a measurement have no effect.
- States are IDLE, ARM, WAIT_TRIG, MEASURE, DRAIN, DONE. All outputs are registered.
- IDLE:
  - start=1 and cfg_chan_en!=0 -> ARM; status cleared to 00.
  - start with mask 0 is ignored.
  - abort is ignored.
- ARM (exactly 1 cycle): counter_clr=mask; enable=0; trig_enable=0. Next state is WAIT_TRIG if cfg_wait_trig, else MEASURE.
- WAIT_TRIG:
  - trig_enable=mask; enable=0; the timeout counter increments from 0.
  - Any bit of (trig_in & mask) high -> MEASURE.
  - Otherwise, if timeout!=0 and count reaches timeout-1 -> DONE with status 10, so the state spends exactly timeout cycles in WAIT_TRIG.
  - Trigger and timeout in the same cycle: trigger wins.
- MEASURE:
  - enable=mask; trig_enable=0.
  - window_remaining is loaded with max(cfg_window,1) on entry and decrements each cycle.
  - When it equals 1 -> DRAIN, so enable is high for exactly max(cfg_window,1) cycles.
- DRAIN: enable=0; held for DRAIN_CYCLES cycles, then DONE; counts are retained (enable low stops counting and does not clear).
- DONE (1 cycle):
  - done=1; enable=trig_enable=counter_clr=0.
  - status is written: 01 from the normal path, 10 on timeout, 11 on abort. It holds until the next accepted start.
  - Next state is IDLE.
- abort=1 in ARM, WAIT_TRIG, MEASURE or DRAIN -> DONE next cycle with status 11. abort has priority over trigger, timeout and window expiry in the same cycle. abort in DONE or IDLE is ignored.
- start while busy=1 is ignored. A start in the DONE cycle is also ignored; the next accepted start is from IDLE.
- trig_in on unselected channels is ignored.
- The counters use no wrap: the timeout counter saturates. A window of 2^WIN_W-1 must complete correctly.

Test Plan:
- No trigger: mask=4'b0101, wait_trig=0, window=5, start at edge N.
  - counter_clr=0101 during N+1.
  - enable=0101 during N+2..N+6.
  - done=1 at N+10 with status=01; busy low at N+11.
- Triggered: mask=4'b0010, wait_trig=1, timeout=0, window=3; trig_in[1] pulsed 20 cycles after ARM.
  - trig_enable=0010 until the trigger.
  - enable=0010 for exactly 3 cycles starting the cycle after the trigger; status=01.
- Timeout: wait_trig=1, timeout=10, no trigger.
  - 10 cycles in WAIT_TRIG, then done with status=10.
  - enable never asserted.
- Abort: abort at MEASURE cycle 2 of window=100.
  - Next cycle DONE, enable=0, status=11.
  - A start in the same cycle is ignored; a later start clears status to 00.
- Edge cases:
  - window=0 gives 1 enable cycle.
  - start with mask=0 leaves busy low.
  - trig_in[3] with mask=0001 is ignored, then a timeout occurs.
  - Trigger and timeout in the same cycle give MEASURE.
  - rst_n_sync low during DRAIN gives IDLE with no done and status=00.
